sb_turn_sequencer: RTL and testbench

//  Parametrised line-follower turn sequencer. Accepts one manoeuvre command per start/done handshake,

---
 rtl/sb_turn_pkg.sv | 39 +++
 rtl/sb_pattern_debounce.sv | 49 ++++
 rtl/sb_turn_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_sb_turn_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_turn_pkg.sv
// rtl/sb_turn_pkg.sv - shared encodings and target-mask helper for the turn sequencer
// Purpose: command encodings, FSM state enum and the sensor target-mask function
//          shared by sb_turn_sequencer and sb_pattern_debounce.
// Ports:   none (package).
package sb_turn_pkg;

   localparam int MAX_SENSORS = 32;

   localparam logic [2:0] CMD_STOP  = 3'd0;
   localparam logic [2:0] CMD_FWD   = 3'd1;
   localparam logic [2:0] CMD_LEFT  = 3'd2;
   localparam logic [2:0] CMD_RIGHT = 3'd3;
   localparam logic [2:0] CMD_UTURN = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEAVE  = 3'd1,
      SEEK   = 3'd2,
      SETTLE = 3'd3,
      DONE   = 3'd4,
      ERR    = 3'd5
   } state_e;

   // One-hot pattern the robot must see once a manoeuvre has finished.
   // Bit n-1 is the leftmost sensor, bit 0 the rightmost.
   function automatic logic [MAX_SENSORS-1:0] target_mask(input logic [2:0] c, input int n);
      logic [MAX_SENSORS-1:0] one;
      logic [MAX_SENSORS-1:0] m;
      one = {{(MAX_SENSORS-1){1'b0}}, 1'b1};
      case (c)
         CMD_FWD:             m = one << (n / 2);
         CMD_LEFT, CMD_UTURN: m = one << (n - 1);
         CMD_RIGHT:           m = one;
         default:             m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/sb_pattern_debounce.sv
// rtl/sb_pattern_debounce.sv - sensor/target comparator with saturating match counter
// Purpose: flags a sensor/target match and counts consecutive matching cycles
//          while the sequencer is searching or settling.
// Ports:   clk_i, rst_ni   clock, asynchronous active-low reset
//          run_i           counting enabled (SEEK or SETTLE)
//          sensors_i       current line-sensor pattern
//          target_i        one-hot target pattern
//          match_o         sensors_i equals target_i this cycle
//          stable_o        match count has reached DEBOUNCE_CYC
module sb_pattern_debounce
   import sb_turn_pkg::*;
#(
   parameter int N_SENSORS    = 3,
   parameter int DEBOUNCE_CYC = 1000,
   parameter int CW           = 26
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 run_i,
   input  logic [N_SENSORS-1:0] sensors_i,
   input  logic [N_SENSORS-1:0] target_i,
   output logic                 match_o,
   output logic                 stable_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   assign match_o  = (sensors_i == target_i);
   assign stable_o = (cnt_q == CW'(DEBOUNCE_CYC));

   // Any mismatch (or leaving the search phases) restarts the run from zero.
   always_comb begin
      cnt_d = cnt_q;
      if (!run_i || !match_o) begin
         cnt_d = '0;
      end else if (cnt_q != '1) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sb_turn_sequencer.sv
// rtl/sb_turn_sequencer.sv - line-follower manoeuvre sequencer with debounced completion
// Purpose: accepts one manoeuvre per start/done handshake, steers motor control and
//          reports completion once the target sensor pattern is stable.
//          Optional timeout watchdog enabled by defining SB_TURN_TIMEOUT_EN.
// Ports:   clk_50     system clock
//          rst_n      asynchronous active-low reset
//          start      command strobe, sampled only when idle
//          cmd        0 STOP, 1 FWD, 2 LEFT, 3 RIGHT, 4 UTURN, 5-7 illegal
//          sensors    line sensors, 1 = on line, MSB = leftmost
//          busy       manoeuvre in progress
//          done       one-cycle completion pulse
//          error      sticky timeout / illegal-command flag
//          motor_cmd  command to motor control, same encoding as cmd
module sb_turn_sequencer
   import sb_turn_pkg::*;
#(
   parameter int N_SENSORS    = 3,
   parameter int DEBOUNCE_CYC = 1000,
   parameter int TIMEOUT_CYC  = 50000000,
   parameter int CW           = 26
) (
   input  logic                 clk_50,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2:0]           cmd,
   input  logic [N_SENSORS-1:0] sensors,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [2:0]           motor_cmd
);

   localparam int CTR = N_SENSORS / 2;

   if ((N_SENSORS < 3) || ((N_SENSORS % 2) == 0) || (N_SENSORS > MAX_SENSORS) ||
       (DEBOUNCE_CYC < 1) || (longint'(TIMEOUT_CYC) >= (longint'(1) << CW))) begin : g_bad_cfg
      $error("sb_turn_sequencer: illegal parameter set");
   end

   state_e               state_q, state_d;
   logic [2:0]           cmd_q, cmd_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 error_q, error_d;
   logic [2:0]           motor_q, motor_d;

   logic [N_SENSORS-1:0] target;
   logic                 node;
   logic [2:0]           steer;
   logic                 run;
   logic                 match;
   logic                 stable;
   logic                 timeout_hit;

   assign target = N_SENSORS'(target_mask(cmd_q, N_SENSORS));
   assign node   = &sensors;
   // At a crossing node every sensor is on line; drive straight through it.
   assign steer  = node ? CMD_FWD : cmd_q;
   assign run    = (state_q == SEEK) || (state_q == SETTLE);

   sb_pattern_debounce #(
      .N_SENSORS    (N_SENSORS),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CW           (CW)
   ) u_debounce (
      .clk_i     (clk_50),
      .rst_ni    (rst_n),
      .run_i     (run),
      .sensors_i (sensors),
      .target_i  (target),
      .match_o   (match),
      .stable_o  (stable)
   );

`ifdef SB_TURN_TIMEOUT_EN
   logic          active;
   logic          accept;
   logic [CW-1:0] to_q, to_d;

   assign active = (state_q == LEAVE) || (state_q == SEEK) || (state_q == SETTLE);
   assign accept = start && !active && (cmd != CMD_STOP) && (cmd <= CMD_UTURN);
   // Fires on the cycle whose increment would bring the count to TIMEOUT_CYC.
   assign timeout_hit = active && (to_q >= CW'(TIMEOUT_CYC - 1));

   always_comb begin
      to_d = to_q;
      if (accept) begin
         to_d = '0;
      end else if (active && (to_q != '1)) begin
         to_d = to_q + CW'(1);
      end
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         to_q <= '0;
      end else begin
         to_q <= to_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // DONE and ERR last one cycle and behave as IDLE, so a new start is taken
   // on the same cycle the done pulse (or error) becomes visible.
   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      error_d = error_q;
      motor_d = motor_q;
      case (state_q)
         IDLE, DONE, ERR: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            motor_d = CMD_STOP;
            if (start) begin
               if (cmd == CMD_STOP) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  error_d = 1'b0;
               end else if (cmd > CMD_UTURN) begin
                  state_d = ERR;
                  error_d = 1'b1;
               end else begin
                  cmd_d   = cmd;
                  busy_d  = 1'b1;
                  error_d = 1'b0;
                  if (cmd == CMD_UTURN) begin
                     state_d = LEAVE;
                     motor_d = CMD_LEFT;
                  end else begin
                     state_d = SEEK;
                     motor_d = node ? CMD_FWD : cmd;
                  end
               end
            end
         end
         LEAVE: begin
            motor_d = CMD_LEFT;
            if (!sensors[CTR]) begin
               state_d = SEEK;
               motor_d = steer;
            end
         end
         SEEK: begin
            motor_d = steer;
            if (match) begin
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            motor_d = steer;
            if (!match) begin
               state_d = SEEK;
            end else if (stable) begin
               state_d = DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               motor_d = CMD_STOP;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            motor_d = CMD_STOP;
         end
      endcase
      if (timeout_hit) begin
         state_d = ERR;
         error_d = 1'b1;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         motor_d = CMD_STOP;
      end
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cmd_q   <= CMD_STOP;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         motor_q <= CMD_STOP;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         error_q <= error_d;
         motor_q <= motor_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign motor_cmd = motor_q;

endmodule

// File: tb/tb_sb_turn_sequencer.sv
// tb/tb_sb_turn_sequencer.sv - self-checking bench for sb_turn_sequencer
module tb_sb_turn_sequencer;

   localparam int N   = 5;
   localparam int DEB = 4;
   localparam int TO  = 64;
`ifdef SB_TURN_TIMEOUT_EN
   localparam bit TO_ON = 1'b1;
`else
   localparam bit TO_ON = 1'b0;
`endif

   logic         clk_50 = 1'b0;
   logic         rst_n;
   logic         start;
   logic [2:0]   cmd;
   logic [N-1:0] sensors;
   logic         busy, done, error;
   logic [2:0]   motor_cmd;

   int checks = 0;
   int errs   = 0;

   always #5 clk_50 = ~clk_50;

   sb_turn_sequencer #(
      .N_SENSORS    (N),
      .DEBOUNCE_CYC (DEB),
      .TIMEOUT_CYC  (TO),
      .CW           (8)
   ) dut (
      .clk_50    (clk_50),
      .rst_n     (rst_n),
      .start     (start),
      .cmd       (cmd),
      .sensors   (sensors),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .motor_cmd (motor_cmd)
   );

   // Model: "active" manoeuvre, optional leave-line phase, length of the
   // current run of target matches and cycles spent since the accept.
   typedef struct packed {
      bit       active;
      bit       leave;
      int       run;
      int       age;
      bit [2:0] c;
      bit       busy;
      bit       done;
      bit       error;
      bit [2:0] motor;
   } mdl_t;

   mdl_t m = '0;

   function automatic logic [N-1:0] tgt_of(input bit [2:0] c);
      case (c)
         3'd1:       return 5'b00100;
         3'd2, 3'd4: return 5'b10000;
         3'd3:       return 5'b00001;
         default:    return 5'b00000;
      endcase
   endfunction

   function automatic mdl_t step(input mdl_t cur, input logic st, input logic [2:0] c, input logic [N-1:0] s);
      mdl_t     n;
      bit [2:0] steer;
      n      = cur;
      n.done = 1'b0;
      steer  = (s == '1) ? 3'd1 : cur.c;
      if (!cur.active) begin
         n.busy  = 1'b0;
         n.motor = 3'd0;
         if (st) begin
            if (c == 3'd0) begin
               n.done  = 1'b1;
               n.error = 1'b0;
            end else if (c > 3'd4) begin
               n.error = 1'b1;
            end else begin
               n.active = 1'b1;
               n.busy   = 1'b1;
               n.error  = 1'b0;
               n.c      = c;
               n.leave  = (c == 3'd4);
               n.run    = 0;
               n.age    = 0;
               n.motor  = (c == 3'd4) ? 3'd2 : ((s == '1) ? 3'd1 : c);
            end
         end
      end else begin
         n.age = cur.age + 1;
         if (TO_ON && n.age >= TO) begin
            n.active = 1'b0;
            n.busy   = 1'b0;
            n.error  = 1'b1;
            n.motor  = 3'd0;
         end else if (cur.leave) begin
            n.motor = 3'd2;
            if (!s[N/2]) begin
               n.leave = 1'b0;
               n.motor = steer;
            end
         end else begin
            n.motor = steer;
            n.run   = (s == tgt_of(cur.c)) ? cur.run + 1 : 0;
            // First match in the search plus DEB debounced matches.
            if (n.run == DEB + 1) begin
               n.active = 1'b0;
               n.busy   = 1'b0;
               n.done   = 1'b1;
               n.motor  = 3'd0;
            end
         end
      end
      return n;
   endfunction

   always @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) m <= '0;
      else        m <= step(m, start, cmd, sensors);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk_50) begin
      chk("busy", 32'(busy), 32'(m.busy));
      chk("done", 32'(done), 32'(m.done));
      chk("error", 32'(error), 32'(m.error));
      chk("motor_cmd", 32'(motor_cmd), 32'(m.motor));
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk_50);
   endtask

   task automatic do_start(input logic [2:0] c, input logic [N-1:0] s);
      start   = 1'b1;
      cmd     = c;
      sensors = s;
      @(negedge clk_50);
      start = 1'b0;
   endtask

   task automatic wait_done(output int k);
      k = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk_50);
         if (done) begin
            k = i;
            break;
         end
      end
   endtask

   initial begin
      int k;
      int k_err;
      bit seen;
      rst_n   = 1'b1;
      start   = 1'b0;
      cmd     = 3'd0;
      sensors = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("reset_busy", 32'(busy), 0);
      chk("reset_done", 32'(done), 0);
      chk("reset_error", 32'(error), 0);
      chk("reset_motor", 32'(motor_cmd), 0);
      tick(2);
      rst_n = 1'b1;
      tick(1);

      // 1: reset in the middle of a LEFT search
      do_start(3'd2, 5'b00000);
      tick(3);
      @(posedge clk_50);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_busy", 32'(busy), 0);
      chk("midreset_motor", 32'(motor_cmd), 0);
      @(negedge clk_50);
      rst_n   = 1'b1;
      sensors = 5'b10000;
      seen    = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_50);
         seen |= done;
      end
      chk("midreset_no_done", 32'(seen), 0);

      // 2: forward, target held from the start
      do_start(3'd1, 5'b00100);
      chk("fwd_motor", 32'(motor_cmd), 1);
      chk("fwd_busy", 32'(busy), 1);
      wait_done(k);
      chk("fwd_done_latency", 32'(k), 5);
      chk("fwd_busy_drop", 32'(busy), 0);
      tick(2);

      // 3: right turn with a one-cycle glitch that restarts the debounce
      do_start(3'd3, 5'b00001);
      chk("right_motor", 32'(motor_cmd), 3);
      tick(3);
      sensors = 5'b00011;
      tick(1);
      sensors = 5'b00001;
      wait_done(k);
      chk("right_glitch_done", 32'(k), 5);
      tick(2);

      // 4: left turn starting on a node
      do_start(3'd2, 5'b11111);
      chk("node_motor_fwd", 32'(motor_cmd), 1);
      tick(1);
      sensors = 5'b10000;
      tick(1);
      chk("node_motor_left", 32'(motor_cmd), 2);
      wait_done(k);
      chk("node_done", 32'(k), 4);
      tick(2);

      // 5: U-turn with leave-line phase
      do_start(3'd4, 5'b00100);
      chk("uturn_leave_motor", 32'(motor_cmd), 2);
      tick(2);
      chk("uturn_still_leaving", 32'(motor_cmd), 2);
      sensors = 5'b00000;
      tick(1);
      chk("uturn_seek_motor", 32'(motor_cmd), 4);
      sensors = 5'b10000;
      wait_done(k);
      chk("uturn_done", 32'(k), 5);
      // back-to-back STOP on the done cycle
      start = 1'b1;
      cmd   = 3'd0;
      @(negedge clk_50);
      start = 1'b0;
      chk("stop_b2b_done", 32'(done), 1);
      chk("stop_b2b_busy", 32'(busy), 0);
      tick(2);

      // 6: illegal command, then stuck sensors
      do_start(3'd6, 5'b00000);
      chk("illegal_error", 32'(error), 1);
      chk("illegal_busy", 32'(busy), 0);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_50);
         seen |= busy;
      end
      chk("illegal_never_busy", 32'(seen), 0);
      do_start(3'd1, 5'b00000);
      chk("accept_clears_error", 32'(error), 0);
      k_err = 0;
      for (int i = 1; i <= 100 && k_err == 0; i++) begin
         start = (i == 10);
         cmd   = 3'd0;
         @(negedge clk_50);
         if (error) k_err = i;
      end
      start = 1'b0;
`ifdef SB_TURN_TIMEOUT_EN
      chk("timeout_cycle", 32'(k_err), 64);
      chk("timeout_motor", 32'(motor_cmd), 0);
      chk("timeout_busy", 32'(busy), 0);
`else
      chk("no_timeout_error", 32'(k_err), 0);
      chk("no_timeout_busy", 32'(busy), 1);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
`endif
      tick(3);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
